// File: rtl/cpu_hazard_pkg.sv
// Shared types and widths for the CPU hazard unit: register IDs, multiplier
// write-back descriptors and the control-state encoding.
package cpu_hazard_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_ID_W = $clog2(NUM_REGS);
  localparam int CF_CNT_W = 3;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  typedef struct packed {
    logic    write_back;
    reg_id_t rd_id;
  } mul_writeback_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    CF   = 2'd1,
    MISS = 2'd2
  } hz_state_t;

endpackage

// File: rtl/cpu_hazard_if.sv
// Hazard-detection bus between the pipeline stages (master) and the hazard
// unit (slave): stage indicators in, pipeline controls and stall counter out.
interface cpu_hazard_if
  import cpu_hazard_pkg::*;
#(
  parameter int MUL_STAGES = 5,
  parameter int CNT_W      = 32
);

  logic                                  execute_mem_read;
  logic                                  execute_wb;
  reg_id_t                               execute_rd;
  logic                                  commit_mem_read;
  reg_id_t                               commit_rd;
  reg_id_t                               decode_ra;
  reg_id_t                               decode_rb;
  reg_id_t                               decode_rd;
  logic                                  ra_use;
  logic                                  rb_use;
  logic                                  rd_use;
  logic                                  branch_decode;
  logic                                  jump_decode;
  mul_writeback_t [MUL_STAGES-1:0]       mul_wb;
  logic                                  cache_miss;
  logic                                  stall;
  logic                                  E_stall;
  logic                                  E_nop;
  logic [CNT_W-1:0]                      stall_cycles;

  modport master (
    output execute_mem_read, execute_wb, execute_rd, commit_mem_read, commit_rd,
           decode_ra, decode_rb, decode_rd, ra_use, rb_use, rd_use,
           branch_decode, jump_decode, mul_wb, cache_miss,
    input  stall, E_stall, E_nop, stall_cycles
  );

  modport slave (
    input  execute_mem_read, execute_wb, execute_rd, commit_mem_read, commit_rd,
           decode_ra, decode_rb, decode_rd, ra_use, rb_use, rd_use,
           branch_decode, jump_decode, mul_wb, cache_miss,
    output stall, E_stall, E_nop, stall_cycles
  );

endinterface

// File: rtl/cpu_hazard_match.sv
// Combinational check of whether the decode-stage instruction actually reads
// (or uses) a given register ID through any of its three operand slots.
module cpu_hazard_match
  import cpu_hazard_pkg::*;
(
  input  reg_id_t decode_ra_i,
  input  reg_id_t decode_rb_i,
  input  reg_id_t decode_rd_i,
  input  logic    ra_use_i,
  input  logic    rb_use_i,
  input  logic    rd_use_i,
  input  reg_id_t reg_i,
  output logic    match_o
);

  assign match_o = (ra_use_i && (decode_ra_i == reg_i)) ||
                   (rb_use_i && (decode_rb_i == reg_i)) ||
                   (rd_use_i && (decode_rd_i == reg_i));

endmodule

// File: rtl/cpu_hazard_unit.sv
// Pipeline hazard unit: same-cycle data hazards, control-flow penalty
// countdown, cache-miss freeze with resume state, saturating stall counter.
module cpu_hazard_unit
  import cpu_hazard_pkg::*;
#(
  parameter int MUL_STAGES = 5,
  parameter int CF_PENALTY = 2,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         reset_n,
  cpu_hazard_if.slave hz
);

  localparam logic [CF_CNT_W-1:0] CF_INIT =
    (CF_PENALTY > 0) ? CF_CNT_W'(CF_PENALTY - 1) : '0;

  hz_state_t             state_q, state_d;
  hz_state_t             ret_state_q, ret_state_d;
  logic [CF_CNT_W-1:0]   cf_cnt_q, cf_cnt_d;
  logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;

  logic                  exe_match;
  logic                  commit_match;
  logic [MUL_STAGES-1:0] mul_hit;
  logic                  cf_issue;
  logic                  data_haz;
  logic                  stall_c, e_stall_c, e_nop_c;

  cpu_hazard_match u_match_exe (
    .decode_ra_i (hz.decode_ra),
    .decode_rb_i (hz.decode_rb),
    .decode_rd_i (hz.decode_rd),
    .ra_use_i    (hz.ra_use),
    .rb_use_i    (hz.rb_use),
    .rd_use_i    (hz.rd_use),
    .reg_i       (hz.execute_rd),
    .match_o     (exe_match)
  );

  cpu_hazard_match u_match_commit (
    .decode_ra_i (hz.decode_ra),
    .decode_rb_i (hz.decode_rb),
    .decode_rd_i (hz.decode_rd),
    .ra_use_i    (hz.ra_use),
    .rb_use_i    (hz.rb_use),
    .rd_use_i    (hz.rd_use),
    .reg_i       (hz.commit_rd),
    .match_o     (commit_match)
  );

  generate
    for (genvar gi = 0; gi < MUL_STAGES; gi++) begin : g_mul
      logic stage_match;
      cpu_hazard_match u_match_mul (
        .decode_ra_i (hz.decode_ra),
        .decode_rb_i (hz.decode_rb),
        .decode_rd_i (hz.decode_rd),
        .ra_use_i    (hz.ra_use),
        .rb_use_i    (hz.rb_use),
        .rd_use_i    (hz.rd_use),
        .reg_i       (hz.mul_wb[gi].rd_id),
        .match_o     (stage_match)
      );
      assign mul_hit[gi] = hz.mul_wb[gi].write_back && stage_match;
    end
  endgenerate

  // A branch needs its operands resolved in decode, so any in-flight writer
  // in execute blocks it, not only loads.
  assign cf_issue = hz.branch_decode || hz.jump_decode;
  assign data_haz = (hz.execute_mem_read && exe_match) ||
                    (hz.commit_mem_read  && commit_match) ||
                    (|mul_hit) ||
                    (cf_issue && hz.execute_wb && exe_match);

  always_comb begin
    state_d     = state_q;
    ret_state_d = ret_state_q;
    cf_cnt_d    = cf_cnt_q;
    if (hz.cache_miss) begin
      state_d = MISS;
      if (state_q != MISS) ret_state_d = state_q;
    end else begin
      case (state_q)
        MISS: state_d = ret_state_q;
        RUN: begin
          if (cf_issue && !data_haz && (CF_PENALTY > 0)) begin
            state_d  = CF;
            cf_cnt_d = CF_INIT;
          end
        end
        CF: begin
          if (cf_cnt_q == '0) state_d = RUN;
          else                cf_cnt_d = cf_cnt_q - 1'b1;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Reset gating sits ahead of the state decode so X inputs cannot leak out.
  always_comb begin
    stall_c   = 1'b0;
    e_stall_c = 1'b0;
    e_nop_c   = 1'b0;
    if (reset_n) begin
      case (state_q)
        RUN: begin
          stall_c = data_haz;
          e_nop_c = data_haz;
        end
        CF: begin
          stall_c = 1'b1;
          e_nop_c = 1'b1;
        end
        MISS: begin
          stall_c   = 1'b1;
          e_stall_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= RUN;
      ret_state_q    <= RUN;
      cf_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      ret_state_q    <= ret_state_d;
      cf_cnt_q       <= cf_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.stall        = stall_c;
  assign hz.E_stall      = e_stall_c;
  assign hz.E_nop        = e_nop_c;
  assign hz.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_cpu_hazard_unit.sv
// Directed bench for cpu_hazard_unit: default instance for hazard/FSM cases,
// a narrow-counter instance for saturation.
module tb_cpu_hazard_unit;
  import cpu_hazard_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  cpu_hazard_if #(.MUL_STAGES(5), .CNT_W(32)) if0 ();
  cpu_hazard_if #(.MUL_STAGES(5), .CNT_W(4))  if1 ();

  cpu_hazard_unit #(.MUL_STAGES(5), .CF_PENALTY(2), .CNT_W(32)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (if0.slave)
  );

  cpu_hazard_unit #(.MUL_STAGES(5), .CF_PENALTY(2), .CNT_W(4)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (if1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear0();
    if0.execute_mem_read = 1'b0; if0.execute_wb = 1'b0; if0.execute_rd = '0;
    if0.commit_mem_read  = 1'b0; if0.commit_rd  = '0;
    if0.decode_ra = '0; if0.decode_rb = '0; if0.decode_rd = '0;
    if0.ra_use = 1'b0; if0.rb_use = 1'b0; if0.rd_use = 1'b0;
    if0.branch_decode = 1'b0; if0.jump_decode = 1'b0;
    if0.mul_wb = '0; if0.cache_miss = 1'b0;
  endtask

  task automatic clear1();
    if1.execute_mem_read = 1'b0; if1.execute_wb = 1'b0; if1.execute_rd = '0;
    if1.commit_mem_read  = 1'b0; if1.commit_rd  = '0;
    if1.decode_ra = '0; if1.decode_rb = '0; if1.decode_rd = '0;
    if1.ra_use = 1'b0; if1.rb_use = 1'b0; if1.rd_use = 1'b0;
    if1.branch_decode = 1'b0; if1.jump_decode = 1'b0;
    if1.mul_wb = '0; if1.cache_miss = 1'b0;
  endtask

  // Inputs are applied at the falling edge; this samples 1 ns later and
  // accounts for the rising edge that will close the cycle.
  task automatic cyc(input string tag, input logic s, input logic es, input logic en);
    #1;
    $display("step %-10s stall=%0b E_stall=%0b E_nop=%0b stall_cycles=%0d",
             tag, if0.stall, if0.E_stall, if0.E_nop, if0.stall_cycles);
    chk({tag, ".stall"},   {31'd0, if0.stall},   {31'd0, s});
    chk({tag, ".E_stall"}, {31'd0, if0.E_stall}, {31'd0, es});
    chk({tag, ".E_nop"},   {31'd0, if0.E_nop},   {31'd0, en});
    chk({tag, ".cnt"},     if0.stall_cycles,     exp_cnt);
    if (s) exp_cnt++;
  endtask

  initial begin
    reset_n = 1'b0;
    clear1();
    if0.execute_mem_read = 1'bx; if0.execute_wb = 1'bx; if0.execute_rd = 'x;
    if0.commit_mem_read  = 1'bx; if0.commit_rd  = 'x;
    if0.decode_ra = 'x; if0.decode_rb = 'x; if0.decode_rd = 'x;
    if0.ra_use = 1'bx; if0.rb_use = 1'bx; if0.rd_use = 1'bx;
    if0.branch_decode = 1'bx; if0.jump_decode = 1'bx;
    if0.mul_wb = 'x; if0.cache_miss = 1'bx;

    @(negedge clk); cyc("rst_x", 0, 0, 0);
    clear0();
    @(negedge clk); reset_n = 1'b1; cyc("idle", 0, 0, 0);

    // Load-use and operand-select cases
    @(negedge clk); if0.execute_mem_read = 1; if0.execute_rd = 5; if0.decode_ra = 5; if0.ra_use = 1;
    cyc("lu", 1, 0, 1);
    @(negedge clk); clear0(); cyc("lu_clr", 0, 0, 0);
    @(negedge clk); if0.execute_mem_read = 1; if0.execute_rd = 5; if0.decode_ra = 5;
    if0.rb_use = 1; if0.decode_rb = 6; cyc("unused", 0, 0, 0);
    @(negedge clk); clear0(); if0.execute_mem_read = 1; if0.execute_rd = 0; if0.decode_rd = 0; if0.rd_use = 1;
    cyc("lu_r0", 1, 0, 1);
    @(negedge clk); clear0(); if0.commit_mem_read = 1; if0.commit_rd = 7; if0.decode_rb = 7; if0.rb_use = 1;
    cyc("lc", 1, 0, 1);
    @(negedge clk); if0.commit_rd = 8; cyc("lc_other", 0, 0, 0);

    // Multiplier pipeline hits
    @(negedge clk); clear0(); if0.mul_wb[4] = {1'b1, 5'd9}; if0.decode_rd = 9; if0.rd_use = 1;
    cyc("mul4", 1, 0, 1);
    @(negedge clk); if0.mul_wb[4] = {1'b0, 5'd9}; cyc("mul4_nowb", 0, 0, 0);
    @(negedge clk); clear0(); if0.mul_wb[0] = {1'b1, 5'd12}; if0.decode_ra = 12; if0.ra_use = 1;
    cyc("mul0", 1, 0, 1);

    // Branch blocked by an execute writer, then issues into the penalty
    @(negedge clk); clear0(); if0.branch_decode = 1; if0.execute_wb = 1; if0.execute_rd = 3;
    if0.decode_ra = 3; if0.ra_use = 1; cyc("bh", 1, 0, 1);
    @(negedge clk); if0.execute_wb = 0; cyc("bh_issue", 0, 0, 0);
    @(negedge clk); clear0(); cyc("bh_cf1", 1, 0, 1);
    @(negedge clk); cyc("bh_cf2", 1, 0, 1);
    @(negedge clk); cyc("bh_run", 0, 0, 0);
    @(negedge clk); if0.execute_wb = 1; if0.execute_rd = 3; if0.decode_ra = 3; if0.ra_use = 1;
    cyc("wb_nobr", 0, 0, 0);

    // Jump penalty
    @(negedge clk); clear0(); if0.jump_decode = 1; cyc("jmp", 0, 0, 0);
    @(negedge clk); clear0(); cyc("j_cf1", 1, 0, 1);
    @(negedge clk); cyc("j_cf2", 1, 0, 1);
    @(negedge clk); cyc("j_run", 0, 0, 0);

    // Cache miss arriving while the penalty still has one cycle left
    @(negedge clk); if0.jump_decode = 1; cyc("m_jmp", 0, 0, 0);
    @(negedge clk); clear0(); if0.cache_miss = 1; cyc("m_cfA", 1, 0, 1);
    @(negedge clk); cyc("m_miss1", 1, 1, 0);
    @(negedge clk); cyc("m_miss2", 1, 1, 0);
    @(negedge clk); if0.cache_miss = 0; cyc("m_miss3", 1, 1, 0);
    @(negedge clk); cyc("m_cf1", 1, 0, 1);
    @(negedge clk); cyc("m_cf2", 1, 0, 1);
    @(negedge clk); cyc("m_run", 0, 0, 0);

    // Miss on the same cycle as a CF entry: miss wins, branch re-triggers
    @(negedge clk); if0.branch_decode = 1; if0.cache_miss = 1; cyc("mb_run", 0, 0, 0);
    @(negedge clk); if0.cache_miss = 0; cyc("mb_miss", 1, 1, 0);
    @(negedge clk); cyc("mb_retry", 0, 0, 0);
    @(negedge clk); clear0(); cyc("mb_cf1", 1, 0, 1);
    @(negedge clk); cyc("mb_cf2", 1, 0, 1);
    @(negedge clk); cyc("mb_run2", 0, 0, 0);

    // Asynchronous reset in the middle of a miss
    @(negedge clk); if0.cache_miss = 1; cyc("rm_run", 0, 0, 0);
    @(negedge clk); cyc("rm_miss", 1, 1, 0);
    #2; reset_n = 1'b0; exp_cnt = 0;
    #1;
    $display("step rm_async stall=%0b E_stall=%0b E_nop=%0b stall_cycles=%0d",
             if0.stall, if0.E_stall, if0.E_nop, if0.stall_cycles);
    chk("rm_async.stall",   {31'd0, if0.stall},   32'd0);
    chk("rm_async.E_stall", {31'd0, if0.E_stall}, 32'd0);
    chk("rm_async.E_nop",   {31'd0, if0.E_nop},   32'd0);
    chk("rm_async.cnt",     if0.stall_cycles,     32'd0);
    @(negedge clk); cyc("rm_hold", 0, 0, 0);
    @(negedge clk); if0.cache_miss = 0; reset_n = 1'b1; cyc("rm_rel", 0, 0, 0);
    @(negedge clk); cyc("rm_after", 0, 0, 0);
    chk("sat.start", {28'd0, if1.stall_cycles}, 32'd0);

    // Saturation on the 4-bit counter instance
    @(negedge clk); if1.execute_mem_read = 1; if1.execute_rd = 4; if1.decode_ra = 4; if1.ra_use = 1;
    #1; chk("sat.stall", {31'd0, if1.stall}, 32'd1);
    repeat (10) @(posedge clk);
    #1; $display("step sat10 stall_cycles=%0d", if1.stall_cycles);
    chk("sat.10", {28'd0, if1.stall_cycles}, 32'd10);
    repeat (10) @(posedge clk);
    #1; $display("step sat20 stall_cycles=%0d", if1.stall_cycles);
    chk("sat.20", {28'd0, if1.stall_cycles}, 32'd15);
    @(negedge clk); clear1();
    repeat (2) @(posedge clk);
    #1; chk("sat.hold", {28'd0, if1.stall_cycles}, 32'd15);
    chk("sat.dut0_cnt", if0.stall_cycles, exp_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_hazard_unit.md
Name: cpu_hazard_unit

Overview:
- Responder (slave) side of the CPU hazard-detection interface.
- Consumes the hazard indicators driven by decode, execute and commit, and produces the global pipeline controls:
  - `stall`: freezes fetch and decode.
  - `E_stall`: freezes the execute stage.
  - `E_nop`: injects a bubble into execute.
- Adds sequential tracking: a control-flow penalty countdown, cache-miss freeze state, and a saturating stall-cycle counter.
- Instantiated once at CPU top level.

Parameters:
- NUM_REGS, 32, architectural register count; register-ID width RW = $clog2(NUM_REGS).
- MUL_STAGES, 5, depth of the multiplier pipeline (number of mul_wb entries).
- CF_PENALTY, 2, stall cycles after a branch/jump leaves decode; legal range 0..7.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- execute_mem_read  in  1  load in execute.
- execute_wb  in  1  instruction in execute writes a register.
- execute_rd  in  RW  execute destination.
- commit_mem_read  in  1  load in commit.
- commit_rd  in  RW  commit destination.
- decode_ra / decode_rb / decode_rd  in  RW each  decode operand IDs.
- ra_use / rb_use / rd_use  in  1 each  operand actually read.
- branch_decode  in  1  branch in decode.
- jump_decode  in  1  jump in decode.
- mul_wb  in  MUL_STAGES x (1+RW)  per-stage {write_back, rd_id}.
- cache_miss  in  1  data/instruction cache miss outstanding.
- stall  out  1  freeze fetch and decode.
- E_stall  out  1  freeze execute.
- E_nop  out  1  bubble into execute.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset:
  - Asynchronous active-low reset on clk domain; one clock.
  - While reset_n=0: FSM=RUN, cf_cnt=0, stall_cycles=0.
  - While reset_n=0, outputs are forced to stall=0, E_stall=0, E_nop=0.
- Decode match:
  - match(r) = (ra_use && decode_ra==r) || (rb_use && decode_rb==r) || (rd_use && decode_rd==r).
  - No special treatment of register 0.
- Combinational hazards (same-cycle, no latency):
  - LU: execute_mem_read && match(execute_rd).
  - LC: commit_mem_read && match(commit_rd).
  - MH: any i with mul_wb[i].write_back && match(mul_wb[i].rd_id).
  - BH: (branch_decode || jump_decode) && execute_wb && match(execute_rd).
  - data_haz = LU || LC || MH || BH.
- FSM states RUN, CF, MISS; outputs per state:
  - RUN: stall=data_haz; E_nop=data_haz; E_stall=0.
  - CF: stall=1; E_nop=1; E_stall=0; cf_cnt decrements each cycle.
  - MISS: stall=1; E_stall=1; E_nop=0. Execute holds its contents, with no bubble.
- Transitions, evaluated in priority order:
  1. cache_miss=1 in any state -> MISS, recording ret_state/cf_cnt unchanged (frozen).
  2. MISS with cache_miss=0 -> ret_state; resume on the next cycle.
  3. RUN, (branch_decode||jump_decode) && !data_haz && CF_PENALTY>0 -> CF, cf_cnt=CF_PENALTY-1. The branch advances this cycle; the penalty starts next cycle.
  4. CF, cf_cnt==0 -> RUN, otherwise cf_cnt-1.
- CF_PENALTY=0: CF is never entered.
- A branch blocked by data_haz stays in decode; CF entry is re-evaluated each cycle until it issues.
- cache_miss on the same cycle as a CF-entry condition: MISS wins and ret_state=RUN. The branch is still in decode after the miss and re-triggers.
- stall_cycles: +1 on each clock edge where stall=1; saturates at all-ones (no wrap).
- Outputs stall/E_stall/E_nop are combinational from state + inputs. No flops on those paths.
- Inputs with X while reset_n=0 must not propagate to the outputs.

Decomposition:
- Shared package cpu_hazard_pkg holds:
  - mul_writeback_t {write_back, rd_id[RW]}.
  - enum hz_state_t {RUN, CF, MISS} (2 bits).
  - Constant REG_ID_W = $clog2(NUM_REGS).
- One sub-module, cpu_hazard_match: purely combinational operand comparator, producing match(r) for a given r. Instantiated 2+MUL_STAGES times (execute_rd, commit_rd, each mul stage).
- FSM, counter and output mux stay in the top.

Test Plan:
- Load-use: execute_mem_read=1, execute_rd=5, decode_ra=5, ra_use=1 -> stall=1, E_nop=1, E_stall=0 that cycle. Next cycle, with inputs cleared -> all 0; stall_cycles=1.
- Unused operand: same as the load-use case but ra_use=0, rb_use=1, decode_rb=6 -> no stall.
- Mul hazard: mul_wb[4]={1,9}, decode_rd=9, rd_use=1 -> stall=1, E_nop=1. With write_back=0 -> stall=0.
- Jump penalty: jump_decode=1 for 1 cycle with no hazard, CF_PENALTY=2 -> stall=1, E_nop=1 for exactly the next 2 cycles, then RUN.
- Miss during CF: enter CF, then assert cache_miss for 3 cycles at cf_cnt=1 -> stall=1, E_stall=1, E_nop=0 for 3 cycles, then 2 more CF cycles; stall_cycles increments by 5.
- Reset mid-MISS: deassert reset_n asynchronously with cache_miss=1 -> outputs 0 immediately, stall_cycles=0. After release with cache_miss=0 -> RUN.
- Counter saturation: CNT_W=4, 20 stall cycles -> stall_cycles holds 15.
